// File: rtl/csr_irq_unit.sv
// csr_irq_unit: machine-mode CSR file and interrupt responder.
// Ports: clk_i/rst_i (sync, active-high); csr_addr_i, csr_wdata_i and
//   csr_write_i/csr_set_i/csr_clear_i CSR strobes; csr_interrupt_i trap
//   entry; csr_mret_i return; pc_i; irq_i async lines.
//   Outputs: csr_rdata_o (old value, comb), mtvec_o, mepc_o, ipending_o.
// Macro CSR_CYCLE_COUNTER_EN adds a 64-bit mcycle at 0xB00/0xB80.
module csr_irq_unit #(
  parameter int          IRQ_W       = 4,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [11:0]      csr_addr_i,
  input  logic [31:0]      csr_wdata_i,
  input  logic             csr_write_i,
  input  logic             csr_set_i,
  input  logic             csr_clear_i,
  input  logic             csr_interrupt_i,
  input  logic             csr_mret_i,
  input  logic [31:0]      pc_i,
  input  logic [IRQ_W-1:0] irq_i,
  output logic [31:0]      csr_rdata_o,
  output logic [31:0]      mtvec_o,
  output logic [31:0]      mepc_o,
  output logic             ipending_o
);

  logic             st_mie_q;
  logic             st_mpie_q;
  logic [IRQ_W-1:0] mie_q;
  logic [IRQ_W-1:0] sync_q;
  logic [IRQ_W-1:0] mip_q;
  logic [31:0]      mtvec_q;
  logic [31:0]      mscratch_q;
  logic [31:0]      mepc_q;
  logic [31:0]      mcause_q;

  logic hit_mstatus;
  logic hit_mie;
  logic hit_mtvec;
  logic hit_mscratch;
  logic hit_mepc;
  logic hit_mcause;
  logic hit_mip;

  assign hit_mstatus  = csr_addr_i == 12'h300;
  assign hit_mie      = csr_addr_i == 12'h304;
  assign hit_mtvec    = csr_addr_i == 12'h305;
  assign hit_mscratch = csr_addr_i == 12'h340;
  assign hit_mepc     = csr_addr_i == 12'h341;
  assign hit_mcause   = csr_addr_i == 12'h342;
  assign hit_mip      = csr_addr_i == 12'h344;

`ifdef CSR_CYCLE_COUNTER_EN
  logic [63:0] cyc_q;
  logic [63:0] cyc_nxt;
  logic        hit_cycl;
  logic        hit_cych;

  assign hit_cycl = csr_addr_i == 12'hB00;
  assign hit_cych = csr_addr_i == 12'hB80;
`endif

  logic [31:0] mstatus_rd;
  logic [31:0] mie_rd;
  logic [31:0] mip_rd;
  logic [IRQ_W-1:0] pend;
  logic [31:0] trap_cause;
  logic [31:0] wr_val;
  logic        op_en;

  assign mstatus_rd = {24'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
  assign mie_rd     = 32'(mie_q) << 16;
  assign mip_rd     = 32'(mip_q) << 16;
  assign pend       = mip_q & mie_q;
  assign ipending_o = st_mie_q & (|pend);
  assign mtvec_o    = mtvec_q;
  assign mepc_o     = mepc_q;

  always_comb begin
    csr_rdata_o = 32'b0;
    unique case (1'b1)
      hit_mstatus:  csr_rdata_o = mstatus_rd;
      hit_mie:      csr_rdata_o = mie_rd;
      hit_mtvec:    csr_rdata_o = mtvec_q;
      hit_mscratch: csr_rdata_o = mscratch_q;
      hit_mepc:     csr_rdata_o = mepc_q;
      hit_mcause:   csr_rdata_o = mcause_q;
      hit_mip:      csr_rdata_o = mip_rd;
`ifdef CSR_CYCLE_COUNTER_EN
      hit_cycl:     csr_rdata_o = cyc_q[31:0];
      hit_cych:     csr_rdata_o = cyc_q[63:32];
`endif
      default:      csr_rdata_o = 32'b0;
    endcase
  end

  // Descending scan so the lowest pending line wins.
  always_comb begin
    trap_cause = 32'h8000_0000;
    for (int i = IRQ_W - 1; i >= 0; i--) begin
      if (pend[i]) trap_cause = 32'h8000_0010 | 32'(i);
    end
  end

  // Trap entry and mret preempt any CSR op in the same cycle.
  assign op_en = (csr_write_i | csr_set_i | csr_clear_i)
               & ~csr_interrupt_i & ~csr_mret_i;

  always_comb begin
    wr_val = csr_rdata_o;
    if (csr_write_i)      wr_val = csr_wdata_i;
    else if (csr_set_i)   wr_val = csr_rdata_o | csr_wdata_i;
    else if (csr_clear_i) wr_val = csr_rdata_o & ~csr_wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= '0;
      sync_q     <= '0;
      mip_q      <= '0;
      mtvec_q    <= MTVEC_RESET & ~32'h3;
      mscratch_q <= 32'b0;
      mepc_q     <= 32'b0;
      mcause_q   <= 32'b0;
    end else begin
      sync_q <= irq_i;
      mip_q  <= sync_q;
      if (csr_interrupt_i) begin
        mepc_q    <= pc_i & ~32'h3;
        mcause_q  <= trap_cause;
        st_mpie_q <= st_mie_q;
        st_mie_q  <= 1'b0;
      end else if (csr_mret_i) begin
        st_mie_q  <= st_mpie_q;
        st_mpie_q <= 1'b1;
      end else if (op_en) begin
        unique case (1'b1)
          hit_mstatus: begin
            st_mie_q  <= wr_val[3];
            st_mpie_q <= wr_val[7];
          end
          hit_mie:      mie_q      <= wr_val[16 +: IRQ_W];
          hit_mtvec:    mtvec_q    <= wr_val & ~32'h3;
          hit_mscratch: mscratch_q <= wr_val;
          hit_mepc:     mepc_q     <= wr_val & ~32'h3;
          hit_mcause:   mcause_q   <= wr_val;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_CYCLE_COUNTER_EN
  // A written half takes the new value; the other keeps counting.
  always_comb begin
    cyc_nxt = cyc_q + 64'd1;
    if (op_en && hit_cycl) cyc_nxt[31:0]  = wr_val;
    if (op_en && hit_cych) cyc_nxt[63:32] = wr_val;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cyc_q <= 64'b0;
    else       cyc_q <= cyc_nxt;
  end
`endif

endmodule

// File: tb/tb_csr_irq_unit.sv
// tb_csr_irq_unit: directed and random checks of csr_irq_unit
// against a behavioural model of the CSR rules.
module tb_csr_irq_unit;
  localparam int IRQ_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [11:0]      csr_addr_i;
  logic [31:0]      csr_wdata_i;
  logic             csr_write_i;
  logic             csr_set_i;
  logic             csr_clear_i;
  logic             csr_interrupt_i;
  logic             csr_mret_i;
  logic [31:0]      pc_i;
  logic [IRQ_W-1:0] irq_i;
  logic [31:0]      csr_rdata_o;
  logic [31:0]      mtvec_o;
  logic [31:0]      mepc_o;
  logic             ipending_o;

  int n_vec = 0;
  int n_err = 0;

  csr_irq_unit #(.IRQ_W(IRQ_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
    .csr_write_i(csr_write_i), .csr_set_i(csr_set_i),
    .csr_clear_i(csr_clear_i),
    .csr_interrupt_i(csr_interrupt_i), .csr_mret_i(csr_mret_i),
    .pc_i(pc_i), .irq_i(irq_i),
    .csr_rdata_o(csr_rdata_o), .mtvec_o(mtvec_o),
    .mepc_o(mepc_o), .ipending_o(ipending_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state, updated once per rising edge.
  logic             m_mie_b, m_mpie;
  logic [31:0]      m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [IRQ_W-1:0] m_irq_prev, m_mip;
  logic [63:0]      m_cyc;

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return {24'b0, m_mpie, 3'b0, m_mie_b, 3'b0};
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return 32'(m_mip) << 16;
`ifdef CSR_CYCLE_COUNTER_EN
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
`endif
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic model_pend();
    return m_mie_b && ((32'(m_mip) << 16) & m_mie) != 0;
  endfunction

  task automatic model_edge();
    logic [31:0] old, nv;
    logic [63:0] cyc;
    int code;
    if (rst_i) begin
      m_mie_b = 0; m_mpie = 0; m_mie = 0;
      m_mtvec = 32'h100; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0;
      m_irq_prev = 0; m_mip = 0; m_cyc = 0;
      return;
    end
    cyc = m_cyc + 1;
    if (csr_interrupt_i) begin
      code = -1;
      for (int i = 0; i < IRQ_W; i++)
        if (code < 0 && m_mip[i] && m_mie[16+i]) code = i;
      m_mcause = (code < 0) ? 32'h8000_0000
                            : 32'h8000_0000 + 32'(16 + code);
      m_mepc = {pc_i[31:2], 2'b00};
      m_mpie = m_mie_b;
      m_mie_b = 0;
    end else if (csr_mret_i) begin
      m_mie_b = m_mpie;
      m_mpie = 1;
    end else if (csr_write_i || csr_set_i || csr_clear_i) begin
      old = model_read(csr_addr_i);
      if (csr_write_i)    nv = csr_wdata_i;
      else if (csr_set_i) nv = old | csr_wdata_i;
      else                nv = old & ~csr_wdata_i;
      case (csr_addr_i)
        12'h300: begin m_mie_b = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mie = nv & 32'h000F_0000;
        12'h305: m_mtvec = {nv[31:2], 2'b00};
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = {nv[31:2], 2'b00};
        12'h342: m_mcause = nv;
`ifdef CSR_CYCLE_COUNTER_EN
        12'hB00: cyc[31:0] = nv;
        12'hB80: cyc[63:32] = nv;
`endif
        default: ;
      endcase
    end
    m_cyc = cyc;
    m_mip = m_irq_prev;
    m_irq_prev = irq_i;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    csr_write_i = 0; csr_set_i = 0; csr_clear_i = 0;
    csr_interrupt_i = 0; csr_mret_i = 0;
  endtask

  // kind: 0 write, 1 set, 2 clear
  task automatic csr_op(input int kind, input logic [11:0] a,
                        input logic [31:0] d);
    idle();
    csr_addr_i = a;
    csr_wdata_i = d;
    csr_write_i = (kind == 0);
    csr_set_i   = (kind == 1);
    csr_clear_i = (kind == 2);
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_i = 1;
    tick();
    tick();
    rst_i = 0;
    csr_addr_i = 12'h305; #1;
    n_vec++;
    if (csr_rdata_o !== 32'h100) begin
      n_err++;
      $display("FAIL reset_mtvec got %h want %h", csr_rdata_o, 32'h100);
    end
    foreach (csr_addr_i[i]) ;
    csr_addr_i = 12'h300; #1;
    n_vec++;
    if (csr_rdata_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mstatus got %h want 0", csr_rdata_o);
    end
    csr_addr_i = 12'h341; #1;
    n_vec++;
    if (csr_rdata_o !== 32'h0 || mepc_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mepc got %h/%h want 0", csr_rdata_o, mepc_o);
    end
    csr_addr_i = 12'h342; #1;
    n_vec++;
    if (csr_rdata_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mcause got %h want 0", csr_rdata_o);
    end
    n_vec++;
    if (ipending_o !== 1'b0 || mtvec_o !== 32'h100) begin
      n_err++;
      $display("FAIL reset_outs got ip=%b mtvec=%h want 0/100",
               ipending_o, mtvec_o);
    end
  endtask

  task automatic test_masking();
    csr_op(1, 12'h300, 32'hFFFF_FFFF);
    csr_addr_i = 12'h300; #1;
    n_vec++;
    if (csr_rdata_o !== 32'h88) begin
      n_err++;
      $display("FAIL mstatus_set got %h want 88", csr_rdata_o);
    end
    csr_op(2, 12'h300, 32'h8);
    csr_addr_i = 12'h300; #1;
    n_vec++;
    if (csr_rdata_o !== 32'h80) begin
      n_err++;
      $display("FAIL mstatus_clr got %h want 80", csr_rdata_o);
    end
    csr_op(0, 12'h305, 32'h3);
    csr_addr_i = 12'h305; #1;
    n_vec++;
    if (csr_rdata_o !== 32'h0 || mtvec_o !== 32'h0) begin
      n_err++;
      $display("FAIL mtvec_mask got %h want 0", csr_rdata_o);
    end
    csr_op(0, 12'h123, 32'hFFFF_FFFF);
    csr_addr_i = 12'h123; #1;
    n_vec++;
    if (csr_rdata_o !== 32'h0) begin
      n_err++;
      $display("FAIL unmapped got %h want 0", csr_rdata_o);
    end
  endtask

  task automatic test_irq_path();
    csr_op(0, 12'h304, 32'h0002_0000);
    csr_op(1, 12'h300, 32'h8);
    irq_i = 4'b0010;
    tick();
    n_vec++;
    if (ipending_o !== 1'b0) begin
      n_err++;
      $display("FAIL irq_edge1 got %b want 0", ipending_o);
    end
    tick();
    n_vec++;
    if (ipending_o !== 1'b1) begin
      n_err++;
      $display("FAIL irq_edge2 got %b want 1", ipending_o);
    end
    pc_i = 32'h0000_0424;
    csr_interrupt_i = 1;
    tick();
    idle();
    csr_addr_i = 12'h342; #1;
    n_vec++;
    if (mepc_o !== 32'h424 || csr_rdata_o !== 32'h8000_0011) begin
      n_err++;
      $display("FAIL trap_entry got mepc=%h mcause=%h want 424/80000011",
               mepc_o, csr_rdata_o);
    end
    csr_addr_i = 12'h300; #1;
    n_vec++;
    if (csr_rdata_o !== 32'h80 || ipending_o !== 1'b0) begin
      n_err++;
      $display("FAIL trap_mstatus got %h ip=%b want 80/0",
               csr_rdata_o, ipending_o);
    end
  endtask

  task automatic test_mret();
    csr_mret_i = 1;
    tick();
    idle();
    csr_addr_i = 12'h300; #1;
    n_vec++;
    if (csr_rdata_o !== 32'h88 || ipending_o !== 1'b1) begin
      n_err++;
      $display("FAIL mret got %h ip=%b want 88/1",
               csr_rdata_o, ipending_o);
    end
  endtask

  task automatic test_priority();
    csr_op(0, 12'h340, 32'h1234_5678);
    csr_op(0, 12'h304, 32'h0005_0000);
    irq_i = 4'b0101;
    tick();
    tick();
    csr_interrupt_i = 1;
    csr_write_i = 1;
    csr_addr_i = 12'h340;
    csr_wdata_i = 32'hDEAD;
    tick();
    idle();
    csr_addr_i = 12'h342; #1;
    n_vec++;
    if (csr_rdata_o !== 32'h8000_0010) begin
      n_err++;
      $display("FAIL prio_cause got %h want 80000010", csr_rdata_o);
    end
    csr_addr_i = 12'h340; #1;
    n_vec++;
    if (csr_rdata_o !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL prio_drop got %h want 12345678", csr_rdata_o);
    end
    csr_mret_i = 1;
    tick();
    idle();
  endtask

  task automatic test_counter();
    csr_op(0, 12'hB00, 32'hFFFF_FFFE);
    tick();
    tick();
`ifdef CSR_CYCLE_COUNTER_EN
    csr_addr_i = 12'hB00; #1;
    n_vec++;
    if (csr_rdata_o !== 32'h0) begin
      n_err++;
      $display("FAIL cyc_lo got %h want 0", csr_rdata_o);
    end
    csr_addr_i = 12'hB80; #1;
    n_vec++;
    if (csr_rdata_o !== 32'h1) begin
      n_err++;
      $display("FAIL cyc_hi got %h want 1", csr_rdata_o);
    end
`else
    csr_addr_i = 12'hB00; #1;
    n_vec++;
    if (csr_rdata_o !== 32'h0) begin
      n_err++;
      $display("FAIL cyc_absent got %h want 0", csr_rdata_o);
    end
`endif
  endtask

  task automatic test_random();
    logic [11:0] addrs [10];
    logic [31:0] exp;
    addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
              12'h342, 12'h344, 12'hB00, 12'hB80, 12'h7C0};
    for (int n = 0; n < 400; n++) begin
      rst_i           = ($urandom_range(0, 79) == 0);
      csr_addr_i      = addrs[$urandom_range(0, 9)];
      csr_wdata_i     = ($urandom_range(0, 3) == 0)
                        ? 32'h0 : $urandom;
      csr_write_i     = ($urandom_range(0, 4) == 0);
      csr_set_i       = ($urandom_range(0, 4) == 0);
      csr_clear_i     = ($urandom_range(0, 4) == 0);
      csr_interrupt_i = ($urandom_range(0, 9) == 0);
      csr_mret_i      = ($urandom_range(0, 9) == 0);
      pc_i            = $urandom;
      if ($urandom_range(0, 3) == 0) irq_i = 4'($urandom);
      #1;
      exp = model_read(csr_addr_i);
      n_vec++;
      if (csr_rdata_o !== exp || ipending_o !== model_pend() ||
          mtvec_o !== m_mtvec || mepc_o !== m_mepc) begin
        n_err++;
        $display("FAIL rand[%0d] a=%h rd=%h/%h ip=%b/%b tv=%h/%h ep=%h/%h",
                 n, csr_addr_i, csr_rdata_o, exp, ipending_o,
                 model_pend(), mtvec_o, m_mtvec, mepc_o, m_mepc);
      end
      tick();
    end
    rst_i = 0;
    idle();
  endtask

  initial begin
    rst_i = 1;
    csr_addr_i = 0;
    csr_wdata_i = 0;
    pc_i = 0;
    irq_i = 0;
    idle();
    test_reset();
    test_masking();
    test_irq_path();
    test_mret();
    test_priority();
    test_counter();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
